// File: rtl/cpu_param_core_if.sv
// Loader and I/O port bundle for cpu_param_core: RAM loader strobe plus
// the input/output handshake ports.
interface cpu_param_core_if #(
  parameter int W  = 3,
  parameter int AW = 3
);
  localparam int IW = W + 8;

  logic          RAM_Write_Enable;
  logic [AW-1:0] RAM_Write_Address;
  logic [IW-1:0] RAM_Write_Data;
  logic [W-1:0]  InD;
  logic          InE;
  logic          In_Ack;
  logic [W-1:0]  OutD;
  logic          Out_Valid;

  modport master (
    output RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data, InD, InE,
    input  In_Ack, OutD, Out_Valid
  );

  modport slave (
    input  RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data, InD, InE,
    output In_Ack, OutD, Out_Valid
  );
endinterface

// File: rtl/cpu_param_core.sv
// Small parameterized accumulator-style CPU: 4 registers, unified
// instruction/data RAM with async read, 2-cycle FETCH/EXEC per instruction.
module cpu_param_core #(
  parameter int W  = 3,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PC_Enable,
  cpu_param_core_if.slave     bus,
  output logic [AW-1:0]       PC,
  output logic [W+7:0]        PI,
  output logic [W-1:0]        REG0,
  output logic [W-1:0]        REG1,
  output logic [W-1:0]        REG2,
  output logic [W-1:0]        REG3,
  output logic                Z,
  output logic                C,
  output logic                Halted
);
  localparam int IW = W + 8;

  localparam logic [3:0] OP_ADDI = 4'd1, OP_ADD  = 4'd2, OP_SUB  = 4'd3,
                         OP_SHL  = 4'd4, OP_CMPI = 4'd5, OP_JZ   = 4'd6,
                         OP_JMP  = 4'd7, OP_LD   = 4'd8, OP_ST   = 4'd9,
                         OP_IN   = 4'd10, OP_OUT = 4'd11, OP_HALT = 4'd12;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_IN, HALT} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       ram [0:(1<<AW)-1];
  logic [3:0][W-1:0]   regs;

  logic [3:0]    op;
  logic [1:0]    rd, rs;
  logic [W-1:0]  imm, rdv, rsv;
  logic [AW-1:0] pc_inc, pc_nxt;
  logic          rf_we, st_we, out_we, ack, z_nxt, c_nxt;
  logic [W-1:0]  rf_wd;
  logic [W:0]    wide;

  assign op  = PI[IW-1:IW-4];
  assign rd  = PI[IW-5:IW-6];
  assign rs  = PI[IW-7:IW-8];
  assign imm = PI[W-1:0];
  assign rdv = regs[rd];
  assign rsv = regs[rs];
  assign pc_inc = PC + AW'(1);

  assign REG0   = regs[0];
  assign REG1   = regs[1];
  assign REG2   = regs[2];
  assign REG3   = regs[3];
  assign Halted = (state == HALT);
  assign bus.In_Ack = ack;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    rf_we     = 1'b0;
    rf_wd     = rdv;
    z_nxt     = Z;
    c_nxt     = C;
    st_we     = 1'b0;
    out_we    = 1'b0;
    ack       = 1'b0;
    wide      = '0;
    case (state)
      IDLE:  if (PC_Enable) state_nxt = FETCH;
      FETCH: state_nxt = EXEC;
      EXEC: begin
        state_nxt = PC_Enable ? FETCH : IDLE;
        pc_nxt    = pc_inc;
        case (op)
          OP_ADDI, OP_ADD: begin
            wide  = {1'b0, rdv} + {1'b0, (op == OP_ADD) ? rsv : imm};
            rf_we = 1'b1;
            rf_wd = wide[W-1:0];
            c_nxt = wide[W];
            z_nxt = (wide[W-1:0] == '0);
          end
          OP_SUB: begin
            // top bit of the widened difference is the borrow
            wide  = {1'b0, rdv} - {1'b0, rsv};
            rf_we = 1'b1;
            rf_wd = wide[W-1:0];
            c_nxt = wide[W];
            z_nxt = (wide[W-1:0] == '0);
          end
          OP_SHL: begin
            rf_we = 1'b1;
            rf_wd = (int'(imm) >= W) ? '0 : (rdv << imm);
            z_nxt = (rf_wd == '0);
          end
          OP_CMPI: begin
            z_nxt = (rdv == imm);
            c_nxt = (rdv < imm);
          end
          OP_JZ:  if (Z) pc_nxt = AW'(imm);
          OP_JMP: pc_nxt = AW'(imm);
          OP_LD: begin
            rf_we = 1'b1;
            rf_wd = ram[AW'(rsv)][W-1:0];
          end
          OP_ST:  st_we = 1'b1;
          OP_IN: begin
            if (bus.InE) begin
              rf_we = 1'b1;
              rf_wd = bus.InD;
              ack   = 1'b1;
            end else begin
              state_nxt = WAIT_IN;
              pc_nxt    = PC;
            end
          end
          OP_OUT: out_we = 1'b1;
          OP_HALT: begin
            state_nxt = HALT;
            pc_nxt    = PC;
          end
          default: ;
        endcase
      end
      WAIT_IN: begin
        if (bus.InE) begin
          rf_we     = 1'b1;
          rf_wd     = bus.InD;
          ack       = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = PC_Enable ? FETCH : IDLE;
        end
      end
      HALT: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC            <= '0;
      PI            <= '0;
      regs          <= '0;
      Z             <= 1'b0;
      C             <= 1'b0;
      bus.OutD      <= '0;
      bus.Out_Valid <= 1'b0;
    end else begin
      PC            <= pc_nxt;
      Z             <= z_nxt;
      C             <= c_nxt;
      bus.Out_Valid <= out_we;
      if (state == FETCH) PI <= ram[PC];
      if (rf_we)          regs[rd] <= rf_wd;
      if (out_we)         bus.OutD <= rdv;
    end
  end

  // ST only fires in EXEC and the loader only in IDLE/HALT, so they never collide
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (st_we)
        ram[AW'(rsv)] <= IW'(rdv);
      else if (bus.RAM_Write_Enable && (state == IDLE || state == HALT))
        ram[bus.RAM_Write_Address] <= bus.RAM_Write_Data;
    end
  end
endmodule

// File: doc/cpu_param_core.md
CPU_PARAM_CORE -- requirements
Module: cpu_param_core

Interface
REQ-001 SHALL provide parameter W, default 3: data/register width, W >= 3.
REQ-002 SHALL provide parameter AW, default 3: address width; RAM = 2^AW words of IW = W+8 bits.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PC_Enable  input  1  run request.
REQ-006 RAM_Write_Enable  input  1  loader write strobe.
REQ-007 RAM_Write_Address  input  AW  loader write address.
REQ-008 RAM_Write_Data  input  IW  loader write word.
REQ-009 InD  input  W  input port data.
REQ-010 InE  input  1  input data valid.
REQ-011 In_Ack  output  1  one-cycle input-accepted pulse.
REQ-012 OutD  output  W  registered output port data.
REQ-013 Out_Valid  output  1  one-cycle OutD-updated pulse.
REQ-014 PC  output  AW  program counter.
REQ-015 PI  output  IW  latched current instruction.
REQ-016 REG0..REG3  output  W each  register file contents.
REQ-017 Z, C, Halted  output  1 each  zero flag, carry/borrow flag, halt status.

Function
REQ-018 Fields: op=PI[IW-1:IW-4], rd=PI[IW-5:IW-6], rs=PI[IW-7:IW-8], imm=PI[W-1:0].
REQ-019 FSM states IDLE, FETCH, EXEC, WAIT_IN, HALT.
REQ-020 IDLE: PC_Enable=1 -> FETCH next cycle; otherwise stay.
REQ-021 FETCH: PI <= RAM[PC] (asynchronous RAM read) -> EXEC; every instruction is exactly 2 cycles except IN waits and HALT.
REQ-022 EXEC: execute PI; PC <= (PC+1) mod 2^AW unless jump taken; next state FETCH if PC_Enable=1, else IDLE.
REQ-023 Opcodes: 0 NOP; 1 ADDI rd+=imm; 2 ADD rd+=rs; 3 SUB rd-=rs; 4 SHL rd<<=imm; 5 CMPI rd vs imm; 6 JZ imm; 7 JMP imm; 8 LD; 9 ST; 10 IN; 11 OUT; 12 HALT; 13-15 NOP.
REQ-024 Arithmetic modulo 2^W; ADD/ADDI: C=carry-out, Z=(result==0); SUB: C=borrow, Z=(result==0).
REQ-025 SHL: shift amount >= W yields 0; Z updated, C unchanged.
REQ-026 CMPI: Z=(rd==imm), C=(rd<imm) unsigned; rd unchanged.
REQ-027 All other opcodes leave Z, C unchanged.
REQ-028 JMP/JZ target = imm zero-extended or truncated to AW bits; JZ taken only when Z=1.
REQ-029 LD: rd <= RAM[R[rs] mod 2^AW][W-1:0]; ST: RAM[R[rs] mod 2^AW] <= R[rd] zero-extended to IW.
REQ-030 IN in EXEC: InE=1 -> rd<=InD, In_Ack=1 that cycle, PC advances; InE=0 -> WAIT_IN, PC held.
REQ-031 WAIT_IN: on first cycle InE=1 perform REQ-030 capture, then FETCH/IDLE per PC_Enable; PC_Enable ignored while waiting.
REQ-032 OUT: OutD <= R[rd] and Out_Valid=1 for exactly the cycle after EXEC; OutD holds until next OUT.
REQ-033 HALT: enter HALT, Halted=1, PC not advanced; exit only by reset.
REQ-034 Loader writes accepted only in IDLE or HALT; ignored in FETCH/EXEC/WAIT_IN, so never collide with ST.
REQ-035 Register/flag updates from EXEC visible to the next instruction's EXEC.

Reset
REQ-036 reset=1 at clk edge: state IDLE, PC=0, PI=0, REG0..3=0, Z=C=0, OutD=0, Out_Valid=In_Ack=Halted=0.
REQ-037 RAM contents unaffected by reset; reset overrides loader write, ST and any mid-instruction or WAIT_IN state.

Verification (W=3, AW=3)
REQ-038 Load ADDI R0,5; ADDI R0,4; HALT; run -> after 6 cycles R0=1, C=1, Z=0, PC=2, Halted=1.
REQ-039 IN R2, InE=0 for 4 cycles then InD=3'b011, InE=1 -> single In_Ack pulse, R2=3, PC 0->1 only then.
REQ-040 CMPI R1,0 (R1=0); JZ 5 -> PC=5; repeat with R1=1 -> PC=2, Z=0, C=0.
REQ-041 ADDI R1,7; ADDI R0,6; ST [R1],R0; LD R3,[R1]; OUT R3 -> RAM[7]=6 zero-extended, R3=6, OutD=6, Out_Valid high 1 cycle.
REQ-042 JMP 7 with NOP at address 7 -> PC wraps 7->0; loader write asserted while running leaves RAM unchanged.
REQ-043 Reset asserted in WAIT_IN -> all outputs per REQ-036 next edge, IDLE, previously loaded RAM words intact.
